// File: rtl/vliw_regfile_sb_pkg.sv
// Shared defaults and types for the VLIW decode-stage register file.
package vliw_pkg;

    localparam int DEF_DATA_W   = 32;
    localparam int DEF_NUM_REGS = 8;
    localparam int DEF_NUM_WR   = 2;
    localparam int DEF_NUM_RD   = 4;

    localparam int SLOT_ALU = 0;
    localparam int SLOT_MEM = 1;

    typedef logic [$clog2(DEF_NUM_REGS)-1:0] reg_addr_t;

endpackage

// File: rtl/vliw_regfile_sb_wr_arbiter.sv
// Per-register write selector: highest enabled port addressing IDX wins,
// and a second hit on the same register raises multi.
module rf_wr_arbiter #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 3,
    parameter int NUM_WR   = 2,
    parameter int IDX      = 0,
    parameter int ZERO_REG = 0
) (
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
    input  logic [NUM_WR*DATA_W-1:0] wr_data,
    output logic                     we,
    output logic [DATA_W-1:0]        data,
    output logic                     multi
);

    localparam logic [ADDR_W-1:0] MY = ADDR_W'(IDX);
    localparam bit DROP = (ZERO_REG != 0) && (IDX == 0);

    always_comb begin
        we    = 1'b0;
        data  = '0;
        multi = 1'b0;
        for (int i = 0; i < NUM_WR; i++) begin
            if (!DROP && wr_en[i] && wr_addr[i*ADDR_W +: ADDR_W] == MY) begin
                multi = multi | we;
                we    = 1'b1;
                data  = wr_data[i*DATA_W +: DATA_W];
            end
        end
    end

endmodule

// File: rtl/vliw_regfile_sb.sv
// Multi-port VLIW register file with write bypass, optional zero register
// and a load scoreboard that drives the decode stall.
module vliw_regfile_sb
    import vliw_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int ADDR_W   = $clog2(NUM_REGS),
    parameter int NUM_WR   = DEF_NUM_WR,
    parameter int NUM_RD   = DEF_NUM_RD,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
    input  logic [NUM_WR*DATA_W-1:0] wr_data,
    input  logic [NUM_RD-1:0]        rd_en,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    input  logic                     iss_valid,
    input  logic [ADDR_W-1:0]        iss_addr,
    output logic [NUM_RD-1:0]        rd_busy,
    output logic                     stall,
    output logic                     err_conflict
);

    logic [DATA_W-1:0]   regs  [NUM_REGS];
    logic [DATA_W-1:0]   wdata [NUM_REGS];
    logic [NUM_REGS-1:0] we_v;
    logic [NUM_REGS-1:0] multi;
    logic [NUM_REGS-1:0] busy;
    logic [ADDR_W-1:0]   ra;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_arb
        rf_wr_arbiter #(
            .DATA_W  (DATA_W),
            .ADDR_W  (ADDR_W),
            .NUM_WR  (NUM_WR),
            .IDX     (g),
            .ZERO_REG(ZERO_REG)
        ) u_arb (
            .wr_en  (wr_en),
            .wr_addr(wr_addr),
            .wr_data(wr_data),
            .we     (we_v[g]),
            .data   (wdata[g]),
            .multi  (multi[g])
        );
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs[r] <= '0;
            end
            busy         <= '0;
            err_conflict <= 1'b0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (we_v[r]) begin
                    regs[r] <= wdata[r];
                end
                // A same-cycle issue re-arms busy after the older result retires
                busy[r] <= (busy[r] & ~we_v[r])
                         | (iss_valid && iss_addr == ADDR_W'(r)
                            && !(ZERO_REG != 0 && r == 0));
            end
            err_conflict <= |multi;
        end
    end

    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        ra      = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            ra = rd_addr[i*ADDR_W +: ADDR_W];
            rd_data[i*DATA_W +: DATA_W] = regs[ra];
            rd_busy[i] = busy[ra];
            if (BYPASS != 0 && we_v[ra]) begin
                rd_data[i*DATA_W +: DATA_W] = wdata[ra];
                rd_busy[i] = 1'b0;
            end
            if (ZERO_REG != 0 && ra == '0) begin
                rd_data[i*DATA_W +: DATA_W] = '0;
            end
        end
    end

    assign stall = |(rd_en & rd_busy);

endmodule

// File: tb/tb_vliw_regfile_sb.sv
// Directed bench: bypass, no-bypass and zero-register builds share stimulus.
module tb_vliw_regfile_sb;
    import vliw_pkg::*;

    logic         clk = 1'b0;
    logic         reset;
    logic [1:0]   wr_en;
    logic [5:0]   wr_addr;
    logic [63:0]  wr_data;
    logic [3:0]   rd_en;
    logic [11:0]  rd_addr;
    logic         iss_valid;
    reg_addr_t    iss_addr;

    logic [127:0] rd_data_a, rd_data_n, rd_data_z;
    logic [3:0]   rd_busy_a, rd_busy_n, rd_busy_z;
    logic         stall_a, stall_n, stall_z;
    logic         err_a, err_n, err_z;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vliw_regfile_sb #(.BYPASS(1), .ZERO_REG(0)) u_a (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data_a), .iss_valid(iss_valid), .iss_addr(iss_addr),
        .rd_busy(rd_busy_a), .stall(stall_a), .err_conflict(err_a)
    );

    vliw_regfile_sb #(.BYPASS(0), .ZERO_REG(0)) u_n (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data_n), .iss_valid(iss_valid), .iss_addr(iss_addr),
        .rd_busy(rd_busy_n), .stall(stall_n), .err_conflict(err_n)
    );

    vliw_regfile_sb #(.BYPASS(1), .ZERO_REG(1)) u_z (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data_z), .iss_valid(iss_valid), .iss_addr(iss_addr),
        .rd_busy(rd_busy_z), .stall(stall_z), .err_conflict(err_z)
    );

    task automatic idle();
        wr_en     = '0;
        wr_addr   = '0;
        wr_data   = '0;
        rd_en     = '0;
        rd_addr   = '0;
        iss_valid = 1'b0;
        iss_addr  = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle();
        step();
        rd_addr[2:0] = 3'd1;
        #1;
        checks++;
        if (rd_data_a[31:0] !== 32'h0 || stall_a !== 1'b0 || err_a !== 1'b0) begin
            errors++;
            $display("FAIL reset_init: data=%h stall=%b err=%b required 0/0/0",
                     rd_data_a[31:0], stall_a, err_a);
        end
        wr_en[SLOT_ALU] = 1'b1;
        wr_addr[2:0]    = 3'd1;
        wr_data[31:0]   = 32'h0000AAAA;
        iss_valid       = 1'b1;
        iss_addr        = 3'd2;
        step();
        idle();
        rd_en        = 4'b0011;
        rd_addr[2:0] = 3'd1;
        rd_addr[5:3] = 3'd2;
        #1;
        checks++;
        if (rd_data_a[31:0] !== 32'h0000AAAA || stall_a !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset: data=%h stall=%b required 0000aaaa/1",
                     rd_data_a[31:0], stall_a);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (rd_data_a[31:0] !== 32'h0 || stall_a !== 1'b0 || err_a !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: data=%h stall=%b err=%b required 0/0/0",
                     rd_data_a[31:0], stall_a, err_a);
        end
        step();
        #2;
        reset = 1'b1;
        step();
        checks++;
        if (rd_data_a[31:0] !== 32'h0 || stall_a !== 1'b0 || stall_n !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: data=%h stall_a=%b stall_n=%b required 0/0/0",
                     rd_data_a[31:0], stall_a, stall_n);
        end
    endtask

    task automatic test_conflict();
        idle();
        wr_en         = 2'b11;
        wr_addr       = {3'd3, 3'd3};
        wr_data       = {32'h22222222, 32'h11111111};
        rd_addr[2:0]  = 3'd3;
        #1;
        checks++;
        if (rd_data_a[31:0] !== 32'h22222222 || err_a !== 1'b0) begin
            errors++;
            $display("FAIL conflict_bypass: data=%h err=%b required 22222222/0",
                     rd_data_a[31:0], err_a);
        end
        step();
        idle();
        rd_addr[2:0] = 3'd3;
        #1;
        checks++;
        if (rd_data_a[31:0] !== 32'h22222222 || rd_data_n[31:0] !== 32'h22222222
            || err_a !== 1'b1) begin
            errors++;
            $display("FAIL conflict_write: a=%h n=%h err=%b required 22222222/22222222/1",
                     rd_data_a[31:0], rd_data_n[31:0], err_a);
        end
        step();
        checks++;
        if (err_a !== 1'b0 || err_n !== 1'b0) begin
            errors++;
            $display("FAIL conflict_pulse: err_a=%b err_n=%b required 0/0", err_a, err_n);
        end
    endtask

    task automatic test_bypass();
        idle();
        wr_en[SLOT_ALU] = 1'b1;
        wr_addr[2:0]    = 3'd5;
        wr_data[31:0]   = 32'h00000055;
        step();
        wr_data[31:0]   = 32'hDEADBEEF;
        rd_addr[5:3]    = 3'd5;
        #1;
        checks++;
        if (rd_data_a[63:32] !== 32'hDEADBEEF || rd_data_n[63:32] !== 32'h00000055) begin
            errors++;
            $display("FAIL bypass_same: a=%h n=%h required deadbeef/00000055",
                     rd_data_a[63:32], rd_data_n[63:32]);
        end
        step();
        idle();
        rd_addr[5:3] = 3'd5;
        #1;
        checks++;
        if (rd_data_n[63:32] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL bypass_next: n=%h required deadbeef", rd_data_n[63:32]);
        end
    endtask

    task automatic test_scoreboard();
        idle();
        iss_valid = 1'b1;
        iss_addr  = 3'd2;
        step();
        idle();
        rd_en[0]     = 1'b1;
        rd_addr[2:0] = 3'd2;
        #1;
        checks++;
        if (stall_a !== 1'b1 || stall_n !== 1'b1 || rd_busy_a !== 4'b0001) begin
            errors++;
            $display("FAIL sb_pending: stall_a=%b stall_n=%b busy=%b required 1/1/0001",
                     stall_a, stall_n, rd_busy_a);
        end
        step();
        checks++;
        if (stall_a !== 1'b1) begin
            errors++;
            $display("FAIL sb_hold: stall=%b required 1", stall_a);
        end
        wr_en[SLOT_MEM] = 1'b1;
        wr_addr[5:3]    = 3'd2;
        wr_data[63:32]  = 32'hCAFE0002;
        #1;
        checks++;
        if (stall_a !== 1'b0 || rd_data_a[31:0] !== 32'hCAFE0002 || stall_n !== 1'b1) begin
            errors++;
            $display("FAIL sb_retire: stall_a=%b data=%h stall_n=%b required 0/cafe0002/1",
                     stall_a, rd_data_a[31:0], stall_n);
        end
        step();
        wr_en = '0;
        #1;
        checks++;
        if (stall_a !== 1'b0 || stall_n !== 1'b0) begin
            errors++;
            $display("FAIL sb_clear: stall_a=%b stall_n=%b required 0/0", stall_a, stall_n);
        end
    endtask

    task automatic test_issue_write();
        idle();
        iss_valid       = 1'b1;
        iss_addr        = 3'd4;
        wr_en[SLOT_ALU] = 1'b1;
        wr_addr[2:0]    = 3'd4;
        wr_data[31:0]   = 32'h00000044;
        step();
        idle();
        rd_en[2]     = 1'b1;
        rd_addr[8:6] = 3'd4;
        #1;
        checks++;
        if (stall_a !== 1'b1 || rd_busy_a[2] !== 1'b1 || rd_data_a[95:64] !== 32'h00000044) begin
            errors++;
            $display("FAIL issue_write: stall=%b busy=%b data=%h required 1/1/00000044",
                     stall_a, rd_busy_a[2], rd_data_a[95:64]);
        end
        wr_en[SLOT_ALU] = 1'b1;
        wr_addr[2:0]    = 3'd4;
        wr_data[31:0]   = 32'h00000045;
        step();
        wr_en = '0;
        #1;
        checks++;
        if (stall_a !== 1'b0 || rd_data_a[95:64] !== 32'h00000045) begin
            errors++;
            $display("FAIL issue_retire: stall=%b data=%h required 0/00000045",
                     stall_a, rd_data_a[95:64]);
        end
    endtask

    task automatic test_zero();
        idle();
        wr_en         = 2'b11;
        wr_addr       = {3'd0, 3'd0};
        wr_data       = {32'h12345678, 32'hFFFFFFFF};
        iss_valid     = 1'b1;
        iss_addr      = 3'd0;
        rd_en[3]      = 1'b1;
        rd_addr[11:9] = 3'd0;
        #1;
        checks++;
        if (rd_data_z[127:96] !== 32'h0 || rd_data_a[127:96] !== 32'h12345678) begin
            errors++;
            $display("FAIL zero_bypass: z=%h a=%h required 0/12345678",
                     rd_data_z[127:96], rd_data_a[127:96]);
        end
        step();
        idle();
        rd_en[3]      = 1'b1;
        rd_addr[11:9] = 3'd0;
        #1;
        checks++;
        if (rd_data_z[127:96] !== 32'h0 || stall_z !== 1'b0 || err_z !== 1'b0) begin
            errors++;
            $display("FAIL zero_reg: data=%h stall=%b err=%b required 0/0/0",
                     rd_data_z[127:96], stall_z, err_z);
        end
        checks++;
        if (rd_data_a[127:96] !== 32'h12345678 || stall_a !== 1'b1 || err_a !== 1'b1) begin
            errors++;
            $display("FAIL zero_plain: data=%h stall=%b err=%b required 12345678/1/1",
                     rd_data_a[127:96], stall_a, err_a);
        end
        step();
        checks++;
        if (err_a !== 1'b0) begin
            errors++;
            $display("FAIL zero_pulse: err=%b required 0", err_a);
        end
    endtask

    initial begin
        reset = 1'b0;
        idle();
        step();
        reset = 1'b1;
        test_reset();
        test_conflict();
        test_bypass();
        test_scoreboard();
        test_issue_write();
        test_zero();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
